// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types and constants for the UART transmit/receive datapath.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Serializer frame phases
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Bit positions inside the UART configuration register
  localparam int unsigned CFG_EN_BIT         = 0;
  localparam int unsigned CFG_PARITY_EN_BIT  = 1;
  localparam int unsigned CFG_PARITY_ODD_BIT = 2;
  localparam int unsigned CFG_STOP2_BIT      = 3;

  // Payload bits per frame
  localparam int unsigned DATA_BITS = 8;

  // Parity bit for a byte: even parity makes the total count of ones even
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                       input logic                 odd);
    return (^data) ^ odd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module  : uart_baud_cnt
// Brief   : Loadable down-counter that measures one bit period. Holds at zero
//           and flags zero both for the current and for the next cycle.
// Revision: 1.0 - initial release
// ============================================================================
module uart_baud_cnt #(
  parameter int unsigned DIV_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_val_i,
  output logic             tick_o,
  output logic             tick_next_o
);

  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Next count: load wins, otherwise count down and saturate at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o      = (cnt_q == '0);
  assign tick_next_o = (cnt_d == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx_ser.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_ser
// Brief   : UART transmit serializer. Pops bytes from the TX FIFO and sends
//           LSB-first frames with optional parity and 1 or 2 stop bits.
//           All outputs come from registers; the pop strobe and tx_done are
//           decided one cycle ahead from the next-state values.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_ser
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_W-1:0]     clk_div,
  input  logic                 cfg_en,
  input  logic                 cfg_parity_en,
  input  logic                 cfg_parity_odd,
  input  logic                 cfg_stop2,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_rdata,
  output logic                 fifo_ren,
  output logic                 uart_tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  // A divisor of zero behaves like one
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_ONE : d;
  endfunction

  tx_state_e            state_q,    state_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic                 par_q,      par_d;
  logic [2:0]           idx_q,      idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DIV_W-1:0]     div_q,      div_d;
  logic                 par_en_q,   par_en_d;
  logic                 stop2_q,    stop2_d;
  logic                 tx_q,       tx_d;
  logic                 busy_q,     busy_d;
  logic                 ren_q,      ren_d;
  logic                 done_q,     done_d;

  logic                 start_frame;
  logic                 cnt_load;
  logic [DIV_W-1:0]     cnt_val;
  logic                 cnt_tick;
  logic                 cnt_tick_next;

  uart_baud_cnt #(
    .DIV_W (DIV_W)
  ) u_baud (
    .clk         (clk),
    .reset       (reset),
    .load_i      (cnt_load),
    .load_val_i  (cnt_val),
    .tick_o      (cnt_tick),
    .tick_next_o (cnt_tick_next)
  );

  // Frame sequencing and look-ahead for the registered strobes
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    par_d       = par_q;
    idx_d       = idx_q;
    stop_idx_d  = stop_idx_q;
    div_d       = div_q;
    par_en_d    = par_en_q;
    stop2_d     = stop2_q;
    start_frame = 1'b0;
    cnt_load    = 1'b0;
    cnt_val     = div_q - DIV_ONE;

    case (state_q)
      ST_IDLE: begin
        // The registered pop strobe marks the capture cycle
        if (ren_q) begin
          start_frame = 1'b1;
        end
      end
      ST_START: begin
        if (cnt_tick) begin
          state_d  = ST_DATA;
          idx_d    = 3'd0;
          cnt_load = 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_tick) begin
          shift_d  = {1'b0, shift_q[DATA_BITS-1:1]};
          cnt_load = 1'b1;
          if (idx_q == 3'd7) begin
            state_d    = par_en_q ? ST_PARITY : ST_STOP;
            stop_idx_d = 1'b0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (cnt_tick) begin
          state_d    = ST_STOP;
          stop_idx_d = 1'b0;
          cnt_load   = 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_tick) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
            cnt_load   = 1'b1;
          end else if (ren_q) begin
            start_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Capture the popped byte and freeze the configuration for this frame
    if (start_frame) begin
      state_d  = ST_START;
      shift_d  = fifo_rdata;
      par_d    = calc_parity(fifo_rdata, cfg_parity_odd);
      div_d    = eff_div(clk_div);
      par_en_d = cfg_parity_en;
      stop2_d  = cfg_stop2;
      cnt_load = 1'b1;
      cnt_val  = eff_div(clk_div) - DIV_ONE;
    end

    // Next cycle is the last cycle of the final stop bit
    done_d = (state_d == ST_STOP) && (stop_idx_d == stop2_q) && cnt_tick_next;

    // Only this block pops the FIFO, so a non-empty flag seen now still holds
    // in the cycle the strobe is presented
    ren_d = cfg_en && !fifo_empty && ((state_d == ST_IDLE) || done_d);

    busy_d = (state_d != ST_IDLE);

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_q;
      default:   tx_d = 1'b1;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      par_q      <= 1'b0;
      idx_q      <= 3'd0;
      stop_idx_q <= 1'b0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ren_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      div_q      <= div_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ren_q      <= ren_d;
      done_q     <= done_d;
    end
  end

  // A reset arriving while a pop is pending must not consume a FIFO entry
  assign fifo_ren = ren_q & ~reset;
  assign uart_tx  = tx_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;

endmodule
`default_nettype wire

// File: doc/uart_tx_ser.md
# uart_tx_ser

Transmit serializer for the UART peripheral. Pops bytes from the TX FIFO and drives the `uart_tx` line as 8-bit LSB-first frames: start bit, optional parity, 1 or 2 stop bits. The bit period comes from the clock-divider register. It sits directly downstream of the UART register block's TX FIFO and is the only driver of the `uart_tx` pin.

## Interface
- `DIV_W`, default 32: width of the bit-period divisor.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clk_div`  in  DIV_W  bit period in `clk` cycles; 0 is treated as 1.
- `cfg_en`  in  1  transmitter enable.
- `cfg_parity_en`  in  1  insert a parity bit after the data.
- `cfg_parity_odd`  in  1  1 = odd parity, 0 = even parity.
- `cfg_stop2`  in  1  1 = two stop bits, 0 = one stop bit.
- `fifo_empty`  in  1  TX FIFO empty flag.
- `fifo_rdata`  in  8  TX FIFO head byte; valid in the same cycle `fifo_ren` is high.
- `fifo_ren`  out  1  one-cycle pop strobe.
- `uart_tx`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is in progress.
- `tx_done`  out  1  one-cycle pulse in the last cycle of the final stop bit.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP.
- **Reset values:** `uart_tx`=1, `fifo_ren`=0, `busy`=0, `tx_done`=0; state=IDLE; counters=0.
- **Frame start.** In IDLE, when `cfg_en` && !`fifo_empty`:
  - assert `fifo_ren` for one cycle and capture `fifo_rdata` into the shift register in that same cycle;
  - latch `clk_div`, parity and stop configuration;
  - go to START next cycle.
- **Mid-frame changes.** Latched configuration is held for the whole frame. Changes to `clk_div` or the cfg inputs mid-frame take effect at the next frame.
- **Bit timing.** The baud counter loads latched_div−1 on entry to each bit and counts down. The bit ends when the counter is 0, so each bit lasts exactly latched_div cycles.
- **START:** `uart_tx`=0 for one bit period, then DATA.
- **DATA:**
  - `uart_tx` = shift[0]; shift right at each bit end.
  - Bit index counts 0..7.
  - After bit 7, go to PARITY if parity is enabled, otherwise STOP.
- **PARITY:** `uart_tx` = XOR of the 8 data bits, XORed with `cfg_parity_odd`. The parity bit is computed at capture time.
- **STOP:**
  - `uart_tx`=1 for 1 or 2 bit periods.
  - `tx_done` pulses in the final cycle.
- **End of frame.**
  - If `cfg_en` && !`fifo_empty` in that final cycle: pop (as at frame start) and go directly to START. There is no idle gap between frames.
  - Otherwise go to IDLE.
- **`busy`:** high in every state except IDLE.
- **`cfg_en` deasserted mid-frame:** the current frame completes; no further pops.
- **`fifo_empty` during a frame:** ignored. The FIFO is only sampled at pop opportunities.
- **Reset mid-frame:**
  - next cycle `uart_tx`=1 and state is IDLE;
  - the in-flight byte is discarded;
  - no `tx_done` pulse.
- **`fifo_ren` rules:** never asserted while `fifo_empty`=1 or `reset`=1.

## Timing
- **Pop to start bit:** 1 cycle. `uart_tx` falls in the cycle after `fifo_ren`.
- **Frame length:** (1 + 8 + P + S) × latched_div cycles, where P ∈ {0,1} and S ∈ {1,2}.
- **Back-to-back frames:** start bit N+1 begins in the cycle immediately after the last stop cycle of frame N.
- **Outputs:** `fifo_ren`, `tx_done`, `busy` and `uart_tx` are all registered outputs.
- **Divisor:** `clk_div`=0 or 1 gives 1 cycle per bit. Maximum bit period is 2^DIV_W−1 cycles, with no wrap.

## Structure
- **Package `uart_pkg`:**
  - state enum;
  - cfg register bit positions: EN=0, PARITY_EN=1, PARITY_ODD=2, STOP2=3;
  - `DATA_BITS`=8.
- **Sub-module `uart_baud_cnt`:**
  - loadable down-counter;
  - ports: load, load value, tick-at-zero output.
  - Will be reused by the RX deserializer.

## Test plan
- div=4, no parity, 1 stop, FIFO holds 0x55:
  - one `fifo_ren` pulse;
  - `uart_tx` = 0 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4 cycles;
  - `tx_done` in cycle 40 after the start bit begins; then idle high.
- div=2, even parity, byte 0x07 → parity bit 1. Odd parity, byte 0x07 → parity bit 0. Frame = 22 cycles.
- div=3, 2 stop bits, FIFO holds 0xA5 then 0x3C:
  - second `fifo_ren` in the last stop cycle of frame 1;
  - second start bit immediately follows, no gap;
  - `busy` stays high for 66 cycles.
- div=0, byte 0xFF: 10-cycle frame, 1 cycle per bit.
- Reset asserted in DATA bit 3:
  - next cycle `uart_tx`=1, `busy`=0;
  - no `tx_done`;
  - after release, the next queued byte transmits normally.
- `cfg_en` dropped mid-frame with 2 bytes queued: the current frame completes, no further `fifo_ren`, line idle high.
